// File: rtl/axioma_mem_pkg.sv
// Shared definitions for the data-memory arbiter: port ids, FSM encoding,
// default timing parameters and the per-requester access bundle.
package axioma_mem_pkg;

    localparam logic [1:0] PID_STK = 2'd0;
    localparam logic [1:0] PID_CPU = 2'd1;
    localparam logic [1:0] PID_DBG = 2'd2;

    localparam int DEF_MEM_LATENCY  = 2;
    localparam int DEF_STARVE_LIMIT = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [7:0]  wdata;
    } mem_req_t;

endpackage

// File: rtl/axioma_dmem_prio_sel.sv
// Winner selection: fixed STK > CPU > DBG order, with DBG forced to the front
// once its starvation flag is raised.
module axioma_dmem_prio_sel
    import axioma_mem_pkg::*;
(
    input  logic [2:0] i_elig,
    input  logic       i_starve,
    output logic       o_valid,
    output logic [1:0] o_id
);

    // i_elig is indexed by port id.
    always_comb begin
        o_valid = |i_elig;
        o_id    = PID_STK;
        if (i_starve && i_elig[PID_DBG]) begin
            o_id = PID_DBG;
        end else if (i_elig[PID_STK]) begin
            o_id = PID_STK;
        end else if (i_elig[PID_CPU]) begin
            o_id = PID_CPU;
        end else if (i_elig[PID_DBG]) begin
            o_id = PID_DBG;
        end
    end

endmodule

// File: rtl/axioma_dmem_arbiter.sv
// Data-memory arbiter: serialises STK/CPU/DBG accesses onto the single SRAM
// controller port and returns read data with a one-cycle acknowledge.
module axioma_dmem_arbiter
    import axioma_mem_pkg::*;
#(
    parameter int MEM_LATENCY  = DEF_MEM_LATENCY,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_stk_req,
    input  logic        i_cpu_req,
    input  logic        i_dbg_req,
    input  logic        i_stk_we,
    input  logic        i_cpu_we,
    input  logic        i_dbg_we,
    input  logic [15:0] i_stk_addr,
    input  logic [15:0] i_cpu_addr,
    input  logic [15:0] i_dbg_addr,
    input  logic [7:0]  i_stk_wdata,
    input  logic [7:0]  i_cpu_wdata,
    input  logic [7:0]  i_dbg_wdata,
    output logic        o_stk_ack,
    output logic        o_cpu_ack,
    output logic        o_dbg_ack,
    output logic [7:0]  o_stk_rdata,
    output logic [7:0]  o_cpu_rdata,
    output logic [7:0]  o_dbg_rdata,
    output logic [15:0] o_mem_addr,
    output logic [7:0]  o_mem_wdata,
    output logic        o_mem_read,
    output logic        o_mem_write,
    input  logic [7:0]  i_mem_rdata,
    input  logic        i_mem_ready,
    output logic        o_busy,
    output logic [1:0]  o_grant_id
);

    // state | meaning
    // IDLE  | no access in flight; arbitrate among eligible requesters
    // ISSUE | one-cycle read or write strobe to the SRAM controller
    // WAIT  | latency countdown, then hold until mem_ready

    localparam logic [3:0] LAT_LOAD   = 4'(MEM_LATENCY - 1);
    localparam logic [3:0] STARVE_THR = 4'(STARVE_LIMIT);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [2:0]  w_req;
    logic [2:0]  w_elig;
    logic [2:0]  r_ack;
    logic        w_starve;
    logic        w_sel_valid;
    logic [1:0]  w_sel_id;
    mem_req_t    w_sel_req;
    logic        w_grant;
    logic        w_done;
    logic        r_we;
    logic [1:0]  r_grant_id;
    logic [15:0] r_mem_addr;
    logic [7:0]  r_mem_wdata;
    logic [7:0]  r_stk_rdata;
    logic [7:0]  r_cpu_rdata;
    logic [7:0]  r_dbg_rdata;
    logic [3:0]  r_lat_cnt;
    logic [3:0]  r_starve_cnt;

    // A port whose ack is high this cycle is masked so a held req is not served twice.
    assign w_req    = {i_dbg_req, i_cpu_req, i_stk_req};
    assign w_elig   = w_req & ~r_ack;
    assign w_starve = (r_starve_cnt >= STARVE_THR);

    axioma_dmem_prio_sel u_prio_sel (
        .i_elig   (w_elig),
        .i_starve (w_starve),
        .o_valid  (w_sel_valid),
        .o_id     (w_sel_id)
    );

    always_comb begin
        case (w_sel_id)
            PID_CPU: w_sel_req = '{we: i_cpu_we, addr: i_cpu_addr, wdata: i_cpu_wdata};
            PID_DBG: w_sel_req = '{we: i_dbg_we, addr: i_dbg_addr, wdata: i_dbg_wdata};
            default: w_sel_req = '{we: i_stk_we, addr: i_stk_addr, wdata: i_stk_wdata};
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_sel_valid) begin
                    w_grant     = 1'b1;
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if ((r_lat_cnt == 4'd0) && i_mem_ready) begin
                    w_done      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_mem_addr  <= 16'h0000;
            r_mem_wdata <= 8'h00;
            r_we        <= 1'b0;
            r_grant_id  <= PID_STK;
            r_lat_cnt   <= 4'd0;
            r_ack       <= 3'b000;
            r_stk_rdata <= 8'h00;
            r_cpu_rdata <= 8'h00;
            r_dbg_rdata <= 8'h00;
        end else begin
            r_ack <= 3'b000;
            if (w_grant) begin
                r_mem_addr  <= w_sel_req.addr;
                r_mem_wdata <= w_sel_req.wdata;
                r_we        <= w_sel_req.we;
                r_grant_id  <= w_sel_id;
            end
            if (r_state == ST_ISSUE) begin
                r_lat_cnt <= LAT_LOAD;
            end else if ((r_state == ST_WAIT) && (r_lat_cnt != 4'd0)) begin
                r_lat_cnt <= r_lat_cnt - 4'd1;
            end
            // Read data is only captured for reads; writes leave rdata untouched.
            if (w_done) begin
                case (r_grant_id)
                    PID_CPU: begin
                        r_ack[PID_CPU] <= 1'b1;
                        if (!r_we) r_cpu_rdata <= i_mem_rdata;
                    end
                    PID_DBG: begin
                        r_ack[PID_DBG] <= 1'b1;
                        if (!r_we) r_dbg_rdata <= i_mem_rdata;
                    end
                    default: begin
                        r_ack[PID_STK] <= 1'b1;
                        if (!r_we) r_stk_rdata <= i_mem_rdata;
                    end
                endcase
            end
        end
    end

    // Counts grants lost by a waiting DBG; saturates rather than wrapping.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_starve_cnt <= 4'd0;
        end else if (!i_dbg_req) begin
            r_starve_cnt <= 4'd0;
        end else if (w_grant) begin
            if (w_sel_id == PID_DBG) begin
                r_starve_cnt <= 4'd0;
            end else if (r_starve_cnt != 4'hF) begin
                r_starve_cnt <= r_starve_cnt + 4'd1;
            end
        end
    end

    assign o_mem_read  = (r_state == ST_ISSUE) && !r_we;
    assign o_mem_write = (r_state == ST_ISSUE) && r_we;
    assign o_busy      = (r_state != ST_IDLE);
    assign o_grant_id  = r_grant_id;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_stk_ack   = r_ack[PID_STK];
    assign o_cpu_ack   = r_ack[PID_CPU];
    assign o_dbg_ack   = r_ack[PID_DBG];
    assign o_stk_rdata = r_stk_rdata;
    assign o_cpu_rdata = r_cpu_rdata;
    assign o_dbg_rdata = r_dbg_rdata;

endmodule

// File: tb/tb_axioma_dmem_arbiter.sv
// Bench for axioma_dmem_arbiter: directed scenarios plus random traffic,
// all checked every cycle against a transaction-level reference model.
module tb_axioma_dmem_arbiter;
    import axioma_mem_pkg::*;

    localparam int LAT  = 2;
    localparam int SLIM = 8;

    logic        clk;
    logic        rst_n;
    logic        stk_req, cpu_req, dbg_req;
    logic        stk_we, cpu_we, dbg_we;
    logic [15:0] stk_addr, cpu_addr, dbg_addr;
    logic [7:0]  stk_wdata, cpu_wdata, dbg_wdata;
    logic        stk_ack, cpu_ack, dbg_ack;
    logic [7:0]  stk_rdata, cpu_rdata, dbg_rdata;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_read, mem_write;
    logic [7:0]  mem_rdata;
    logic        mem_ready;
    logic        busy;
    logic [1:0]  grant_id;

    axioma_dmem_arbiter #(.MEM_LATENCY(LAT), .STARVE_LIMIT(SLIM)) dut (
        .i_clk       (clk),
        .i_reset_n   (rst_n),
        .i_stk_req   (stk_req),
        .i_cpu_req   (cpu_req),
        .i_dbg_req   (dbg_req),
        .i_stk_we    (stk_we),
        .i_cpu_we    (cpu_we),
        .i_dbg_we    (dbg_we),
        .i_stk_addr  (stk_addr),
        .i_cpu_addr  (cpu_addr),
        .i_dbg_addr  (dbg_addr),
        .i_stk_wdata (stk_wdata),
        .i_cpu_wdata (cpu_wdata),
        .i_dbg_wdata (dbg_wdata),
        .o_stk_ack   (stk_ack),
        .o_cpu_ack   (cpu_ack),
        .o_dbg_ack   (dbg_ack),
        .o_stk_rdata (stk_rdata),
        .o_cpu_rdata (cpu_rdata),
        .o_dbg_rdata (dbg_rdata),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .o_mem_read  (mem_read),
        .o_mem_write (mem_write),
        .i_mem_rdata (mem_rdata),
        .i_mem_ready (mem_ready),
        .o_busy      (busy),
        .o_grant_id  (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_fail;
    int cyc;

    // Requester (master) state, index = port id
    logic        p_pend [3];
    logic        p_we   [3];
    logic [15:0] p_addr [3];
    logic [7:0]  p_wd   [3];

    // Reference model: one access in flight, ack at the first edge at least
    // LAT+1 after issue with mem_ready high; next arbitration the edge after.
    int          m_owner;
    int          m_issue;
    int          m_next_arb;
    int          m_mask;
    int          m_starve;
    logic        m_we;
    logic [15:0] m_addr;
    logic [7:0]  m_wd;
    logic [1:0]  m_gid;
    logic [7:0]  m_rd [3];
    logic [2:0]  e_ack;
    logic        e_rd, e_wr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic drive();
        stk_req = p_pend[0]; stk_we = p_we[0]; stk_addr = p_addr[0]; stk_wdata = p_wd[0];
        cpu_req = p_pend[1]; cpu_we = p_we[1]; cpu_addr = p_addr[1]; cpu_wdata = p_wd[1];
        dbg_req = p_pend[2]; dbg_we = p_we[2]; dbg_addr = p_addr[2]; dbg_wdata = p_wd[2];
    endtask

    task automatic new_txn(input int i, input logic we, input logic [15:0] a, input logic [7:0] d);
        p_pend[i] = 1'b1; p_we[i] = we; p_addr[i] = a; p_wd[i] = d;
    endtask

    task automatic m_reset();
        m_owner = -1; m_issue = 0; m_next_arb = 0; m_mask = -1; m_starve = 0;
        m_we = 1'b0; m_addr = 16'h0; m_wd = 8'h0; m_gid = 2'd0;
        for (int i = 0; i < 3; i++) m_rd[i] = 8'h00;
    endtask

    task automatic chk_reset_outputs();
        chk("rst_acks", {dbg_ack, cpu_ack, stk_ack}, 3'b000);
        chk("rst_strobes", {mem_read, mem_write}, 2'b00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_grant_id", grant_id, 2'd0);
        chk("rst_mem_addr", mem_addr, 16'h0);
        chk("rst_mem_wdata", mem_wdata, 8'h0);
        chk("rst_rdata", {stk_rdata, cpu_rdata, dbg_rdata}, 24'h0);
    endtask

    task automatic step();
        int         w;
        logic [2:0] elig;
        logic       granted;
        drive();
        @(posedge clk);
        #1;
        cyc++;
        e_ack = 3'b000; e_rd = 1'b0; e_wr = 1'b0; granted = 1'b0; w = -1; elig = 3'b000;
        if (m_owner >= 0) begin
            if ((cyc >= m_issue + LAT + 1) && mem_ready) begin
                e_ack[m_owner] = 1'b1;
                if (!m_we) m_rd[m_owner] = mem_rdata;
                m_next_arb = cyc + 1;
                m_mask = m_owner;
                m_owner = -1;
            end
        end else if (cyc >= m_next_arb) begin
            for (int i = 0; i < 3; i++)
                elig[i] = p_pend[i] && !((cyc == m_next_arb) && (m_mask == i));
            if ((m_starve >= SLIM) && elig[2]) w = 2;
            else for (int i = 2; i >= 0; i--) if (elig[i]) w = i;
            if (w >= 0) begin
                granted = 1'b1;
                m_owner = w; m_issue = cyc;
                m_we = p_we[w]; m_addr = p_addr[w]; m_wd = p_wd[w]; m_gid = 2'(w);
                e_rd = !p_we[w]; e_wr = p_we[w];
            end
        end
        if (!p_pend[2]) m_starve = 0;
        else if (granted) m_starve = (w == 2) ? 0 : ((m_starve < 15) ? m_starve + 1 : 15);

        chk("ack", {dbg_ack, cpu_ack, stk_ack}, e_ack);
        chk("mem_read", mem_read, e_rd);
        chk("mem_write", mem_write, e_wr);
        chk("busy", busy, (m_owner >= 0) ? 1'b1 : 1'b0);
        chk("grant_id", grant_id, m_gid);
        chk("mem_addr", mem_addr, m_addr);
        chk("mem_wdata", mem_wdata, m_wd);
        chk("stk_rdata", stk_rdata, m_rd[0]);
        chk("cpu_rdata", cpu_rdata, m_rd[1]);
        chk("dbg_rdata", dbg_rdata, m_rd[2]);
    endtask

    task automatic wait_ack(input int i, input int bound, input string tag);
        logic got;
        logic [2:0] av;
        got = 1'b0;
        for (int c = 0; c < bound && !got; c++) begin
            step();
            av = {dbg_ack, cpu_ack, stk_ack};
            got = av[i];
        end
        chk(tag, got, 1'b1);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < 3; i++) p_pend[i] = 1'b0;
        repeat (n) step();
    endtask

    int         t_stk, t_cpu, losses, dbg_wins, lost1, lost2;
    logic [2:0] av;

    initial begin
        n_checks = 0; n_fail = 0; cyc = 0;
        for (int i = 0; i < 3; i++) begin
            p_pend[i] = 1'b0; p_we[i] = 1'b0; p_addr[i] = 16'h0; p_wd[i] = 8'h0;
        end
        m_reset();
        mem_ready = 1'b1; mem_rdata = 8'h00; rst_n = 1'b0;
        drive();
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;

        // Single CPU read
        mem_rdata = 8'hA5;
        new_txn(1, 1'b0, 16'h0123, 8'h00);
        step();
        chk("t1_mem_read", mem_read, 1'b1);
        chk("t1_mem_addr", mem_addr, 16'h0123);
        step();
        chk("t1_read_one_cycle", mem_read, 1'b0);
        step();
        chk("t1_no_early_ack", cpu_ack, 1'b0);
        step();
        chk("t1_ack_edge4", cpu_ack, 1'b1);
        chk("t1_rdata", cpu_rdata, 8'hA5);
        p_pend[1] = 1'b0;
        step();
        chk("t1_ack_pulse", cpu_ack, 1'b0);
        chk("t1_rdata_held", cpu_rdata, 8'hA5);
        drain(2);

        // Simultaneous STK write and CPU read
        mem_rdata = 8'hC3;
        new_txn(0, 1'b1, 16'h08FF, 8'h3C);
        new_txn(1, 1'b0, 16'h0321, 8'h00);
        step();
        chk("t2_stk_write", {mem_write, mem_read}, 2'b10);
        chk("t2_stk_addr", mem_addr, 16'h08FF);
        chk("t2_stk_wdata", mem_wdata, 8'h3C);
        t_stk = -1; t_cpu = -1;
        for (int c = 0; c < 30 && t_cpu < 0; c++) begin
            step();
            if (stk_ack) begin t_stk = cyc; p_pend[0] = 1'b0; end
            if (cpu_ack) begin t_cpu = cyc; p_pend[1] = 1'b0; end
        end
        chk("t2_ack_spacing", t_cpu - t_stk, LAT + 2);
        chk("t2_cpu_rdata", cpu_rdata, 8'hC3);
        drain(2);

        // DBG starvation override
        mem_rdata = 8'h11;
        new_txn(0, 1'b0, 16'h0100, 8'h00);
        new_txn(1, 1'b1, 16'h0200, 8'h22);
        new_txn(2, 1'b0, 16'h0D00, 8'h00);
        losses = 0; dbg_wins = 0; lost1 = -1; lost2 = -1;
        for (int c = 0; c < 200 && dbg_wins < 2; c++) begin
            step();
            if (mem_read || mem_write) begin
                if (grant_id == PID_DBG) begin
                    dbg_wins++;
                    if (dbg_wins == 1) lost1 = losses; else lost2 = losses;
                    losses = 0;
                end else begin
                    losses++;
                end
            end
            av = {dbg_ack, cpu_ack, stk_ack};
            for (int i = 0; i < 3; i++)
                if (av[i]) new_txn(i, 1'($urandom), 16'($urandom), 8'($urandom));
        end
        chk("t3_losses_before_dbg", lost1, SLIM);
        chk("t3_losses_after_clear", lost2, SLIM);
        drain(8);

        // mem_ready stall
        mem_ready = 1'b0; mem_rdata = 8'h5A;
        new_txn(1, 1'b0, 16'h0200, 8'h00);
        step();
        chk("t4_issue", mem_read, 1'b1);
        for (int c = 0; c < 10; c++) begin
            step();
            chk("t4_busy_stall", busy, 1'b1);
            chk("t4_no_ack_stall", cpu_ack, 1'b0);
        end
        mem_ready = 1'b1;
        step();
        chk("t4_ack_after_ready", cpu_ack, 1'b1);
        chk("t4_rdata", cpu_rdata, 8'h5A);
        drain(2);

        // Reset during WAIT of a CPU read
        mem_rdata = 8'h77;
        new_txn(1, 1'b0, 16'h0456, 8'h00);
        step();
        step();
        chk("t5_in_wait", busy, 1'b1);
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs();
        m_reset();
        #1 rst_n = 1'b1;
        step();
        chk("t5_rearb_read", mem_read, 1'b1);
        chk("t5_rearb_addr", mem_addr, 16'h0456);
        wait_ack(1, 20, "t5_ack_seen");
        chk("t5_rdata", cpu_rdata, 8'h77);
        drain(2);

        // Ack mask: req held one extra cycle, then two extra cycles
        new_txn(1, 1'b0, 16'h0777, 8'h00);
        wait_ack(1, 20, "t6a_ack_seen");
        step();
        chk("t6a_masked_no_read", mem_read, 1'b0);
        chk("t6a_masked_idle", busy, 1'b0);
        p_pend[1] = 1'b0;
        step();
        chk("t6a_stays_idle", busy, 1'b0);
        new_txn(1, 1'b0, 16'h0778, 8'h00);
        wait_ack(1, 20, "t6b_ack_seen");
        step();
        chk("t6b_masked_no_read", mem_read, 1'b0);
        step();
        chk("t6b_new_access", mem_read, 1'b1);
        wait_ack(1, 20, "t6b_second_ack");
        drain(2);

        // Random traffic
        for (int c = 0; c < 800; c++) begin
            mem_ready = ($urandom_range(3) != 0);
            mem_rdata = 8'($urandom);
            step();
            av = {dbg_ack, cpu_ack, stk_ack};
            for (int i = 0; i < 3; i++) begin
                if (av[i]) p_pend[i] = 1'b0;
                if (!p_pend[i] && ($urandom_range(2) != 0))
                    new_txn(i, 1'($urandom), 16'($urandom), 8'($urandom));
            end
        end
        mem_ready = 1'b1;
        drain(6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axioma_dmem_arbiter.md
Name: axioma_dmem_arbiter

Overview:
- Arbitrates the single-ported data-memory/SRAM controller interface between three requesters: the stack engine (STK), the CPU load/store unit (CPU), and the debug/DMA port (DBG).
- Serialises accesses, sequences each one through issue and wait phases, and returns read data with a one-cycle acknowledge.
- Sits between the core/debug logic and the SRAM controller's data_addr/data_in/data_out/data_read/data_write/data_ready port.

Parameters:
- MEM_LATENCY, 2, minimum cycles from issue until memory read data is valid (range 1..15).
- STARVE_LIMIT, 8, number of consecutive lost arbitrations after which DBG is forced to win (range 1..15).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- stk_req, cpu_req, dbg_req  in  1 each  level request; held until the matching ack is seen
- stk_we, cpu_we, dbg_we  in  1 each  1 = write, 0 = read
- stk_addr, cpu_addr, dbg_addr  in  16 each  byte address
- stk_wdata, cpu_wdata, dbg_wdata  in  8 each  write data
- stk_ack, cpu_ack, dbg_ack  out  1 each  single-cycle completion pulse
- stk_rdata, cpu_rdata, dbg_rdata  out  8 each  read result, valid while ack is high and held afterwards
- mem_addr  out  16  address to the SRAM controller
- mem_wdata  out  8  write data to the SRAM controller
- mem_read, mem_write  out  1 each  one-cycle command strobes
- mem_rdata  in  8  read data from the SRAM controller
- mem_ready  in  1  controller ready/complete
- busy  out  1  high in any state other than IDLE
- grant_id  out  2  current or last owner: 0 = STK, 1 = CPU, 2 = DBG; 3 is never driven

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous and active-low.
- Reset values: all outputs 0, the FSM in IDLE, and all counters 0. Assertion mid-access abandons the access: no ack is issued and the strobes drop immediately.
- FSM states are IDLE, ISSUE and WAIT.
- IDLE:
  - Eligible requesters are those with req=1 and ack=0 in this cycle. The ack mask prevents double service.
  - If any requester is eligible: select a winner; latch its addr, wdata, we and id into mem_addr, mem_wdata, an internal we flag and grant_id; go to ISSUE.
- ISSUE (exactly one cycle):
  - mem_read = !we and mem_write = we.
  - Load the latency counter with MEM_LATENCY-1; go to WAIT.
- WAIT:
  - If the counter is non-zero, decrement it.
  - If the counter is zero and mem_ready=1: pulse the winner's ack for one cycle, capture mem_rdata into the winner's rdata (reads only; rdata is unchanged on writes), and go to IDLE.
  - If the counter is zero and mem_ready=0: stay in WAIT indefinitely.
- Timing with MEM_LATENCY=2:
  - A req sampled at edge 1 gives ISSUE during cycle 1 and ack high after edge 4.
  - The general rule is ack at edge MEM_LATENCY+2.
  - Back-to-back accesses: one access per MEM_LATENCY+2 cycles.
- Priority: fixed order STK > CPU > DBG, with a starvation override for DBG.
- DBG starvation counter (4 bits):
  - Increments (saturating) at each IDLE->ISSUE transition that grants another port while dbg_req=1.
  - Clears on a DBG grant or when dbg_req=0.
  - When the counter is >= STARVE_LIMIT, DBG wins regardless of the other requests.
- Requests arriving or dropping outside IDLE are ignored until the next IDLE. A request withdrawn before grant is never serviced.
- mem_addr and mem_wdata hold their value between accesses; no address range checking is done in this block.

Decomposition:
- Package axioma_mem_pkg holds:
  - port-id constants PID_STK=0, PID_CPU=1, PID_DBG=2
  - FSM state encodings
  - MEM_LATENCY and STARVE_LIMIT defaults
- One combinational sub-module, axioma_dmem_prio_sel. Inputs: the three eligible bits and the starve flag. Outputs: a valid bit and the 2-bit winner id.

Test Plan:
- Single CPU read: mem_rdata=8'hA5, MEM_LATENCY=2 -> mem_read high one cycle with mem_addr=0x0123; cpu_ack one cycle at edge 4; cpu_rdata=8'hA5.
- Simultaneous STK write (0x08FF, 0x3C) and CPU read -> STK is served first (mem_write with 0x08FF/0x3C), then CPU; the acks are MEM_LATENCY+2 cycles apart.
- dbg_req held while STK and CPU request continuously -> after 8 lost grants, DBG wins the 9th arbitration; the counter then clears.
- mem_ready held 0 for 10 cycles after issue -> FSM stays in WAIT and busy=1; ack is issued the cycle after mem_ready rises.
- reset_n asserted during WAIT of a CPU read -> all strobes, acks and rdata are 0 immediately; after release the pending cpu_req is re-arbitrated from IDLE.
- CPU holds req for one extra cycle after ack -> no second access is issued (ack mask); a req held two cycles after ack starts a new access.
